// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the program counter, issues reads
// to the instruction memory, and hands each fetched word with its PC and
// sequential next-PC to decode. A one-entry skid buffer absorbs decode
// backpressure; redirects from execute flush everything fetched so far.
`timescale 1ns/1ps

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_next_o,
  output logic        valid_o
);

  // REQ: request outstanding; FULL: output and skid both occupied, no request;
  // DROP: the in-flight response belongs to a flushed path and is discarded.
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    FULL = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_q;
  logic [31:0] redir_q;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        slot_free;
  logic        unused_redirect_bits;

  // Targets are word aligned: the low two bits of the redirect are dropped.
  assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc_i[1:0];
  assign pc_plus4             = pc_q + 32'd4;
  // The output slot can take a new word when empty or being consumed now.
  assign slot_free            = !valid_o || !stall_i;

  // Request is combinational on state so it drops immediately under reset.
  assign imem_address = pc_q;
  assign imem_read    = ((state_reg == REQ) || (state_reg == DROP)) && !rst;

  // Fetch FSM with registered output slot, skid entry and pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= REQ;
      pc_q          <= RESET_PC;
      redir_q       <= 32'd0;
      skid_valid    <= 1'b0;
      skid_instr    <= 32'd0;
      skid_pc       <= 32'd0;
      instruction_o <= 32'd0;
      pc_o          <= 32'd0;
      pc_next_o     <= 32'd0;
      valid_o       <= 1'b0;
    end else begin
      case (state_reg)
        REQ: begin
          if (redirect_i) begin
            valid_o <= 1'b0;
            if (imem_resp) begin
              // Response for the old path completes now; restart at target.
              pc_q <= redirect_target;
            end else begin
              // Response still pending: keep the address until it lands.
              redir_q   <= redirect_target;
              state_reg <= DROP;
            end
          end else if (imem_resp && slot_free) begin
            instruction_o <= imem_rdata;
            pc_o          <= pc_q;
            pc_next_o     <= pc_plus4;
            valid_o       <= 1'b1;
            pc_q          <= pc_plus4;
          end else if (imem_resp) begin
            skid_instr <= imem_rdata;
            skid_pc    <= pc_q;
            skid_valid <= 1'b1;
            pc_q       <= pc_plus4;
            state_reg  <= FULL;
          end else if (!stall_i) begin
            valid_o <= 1'b0;
          end
        end

        FULL: begin
          if (redirect_i) begin
            valid_o    <= 1'b0;
            skid_valid <= 1'b0;
            pc_q       <= redirect_target;
            state_reg  <= REQ;
          end else if (!stall_i) begin
            instruction_o <= skid_instr;
            pc_o          <= skid_pc;
            pc_next_o     <= skid_pc + 32'd4;
            valid_o       <= 1'b1;
            skid_valid    <= 1'b0;
            state_reg     <= REQ;
          end
        end

        DROP: begin
          valid_o <= 1'b0;
          if (imem_resp) begin
            pc_q      <= redirect_i ? redirect_target : redir_q;
            state_reg <= REQ;
          end else if (redirect_i) begin
            redir_q <= redirect_target;
          end
        end

        default: begin
          state_reg <= REQ;
          valid_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a queue-level model of
// the fetch pipeline (up to two undelivered words, plus a discard flag for a
// response that belongs to a flushed path) and a per-cycle compare process.
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0060;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic [31:0] pc_next_o;
  logic        valid_o;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_address  (imem_address),
    .imem_read     (imem_read),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .pc_next_o     (pc_next_o),
    .valid_o       (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Memory image: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory responder: answers after `lat` cycles of continuous request.
  int   lat        = 1;
  logic force_resp = 1'b0;
  initial begin
    int cnt;
    cnt        = 0;
    imem_resp  = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      if (force_resp) begin
        cnt        = 0;
        imem_resp  = 1'b1;
        imem_rdata = mem_word(imem_address);
      end else if (imem_read) begin
        cnt++;
        if (cnt >= lat) begin
          cnt        = 0;
          imem_resp  = 1'b1;
          imem_rdata = mem_word(imem_address);
        end else begin
          imem_resp = 1'b0;
        end
      end else begin
        cnt       = 0;
        imem_resp = 1'b0;
      end
    end
  end

  // Model: words fetched but not yet taken by decode, oldest first.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetched_t;

  fetched_t    mq[$];
  logic [31:0] m_pc;
  logic        m_drop;
  logic [31:0] m_tgt;
  logic        m_ready = 1'b0;

  initial begin
    logic        rd_act;
    logic [31:0] tgt;
    fetched_t    ent;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_pc    = RST_PC;
        m_drop  = 1'b0;
        m_tgt   = 32'd0;
        m_ready = 1'b1;
      end else if (m_ready) begin
        rd_act = m_drop || (mq.size() < 2);
        if (redirect_i) begin
          tgt = {redirect_pc_i[31:2], 2'b00};
          mq.delete();
          if (rd_act && !imem_resp) begin
            m_drop = 1'b1;
            m_tgt  = tgt;
          end else begin
            m_pc   = tgt;
            m_drop = 1'b0;
          end
        end else begin
          if (mq.size() > 0 && !stall_i) ent = mq.pop_front();
          if (m_drop) begin
            if (imem_resp) begin
              m_pc   = m_tgt;
              m_drop = 1'b0;
            end
          end else if (rd_act && imem_resp) begin
            ent.instr = imem_rdata;
            ent.pc    = m_pc;
            mq.push_back(ent);
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Per-cycle compare of every DUT output against the model.
  initial begin
    logic exp_read;
    forever begin
      @(posedge clk);
      #2;
      if (m_ready) begin
        exp_read = !rst && (m_drop || (mq.size() < 2));
        chk("m_imem_read", 32'(imem_read), 32'(exp_read));
        chk("m_imem_address", imem_address, m_pc);
        chk("m_valid_o", 32'(valid_o), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
          chk("m_instruction_o", instruction_o, mq[0].instr);
          chk("m_pc_o", pc_o, mq[0].pc);
          chk("m_pc_next_o", pc_next_o, mq[0].pc + 32'd4);
        end
      end
    end
  end

  task automatic wait_valid(input string nm, input int budget);
    for (int i = 0; i < budget && !valid_o; i++) @(negedge clk);
    chk(nm, 32'(valid_o), 32'd1);
  endtask

  task automatic wait_full(input string nm, input int budget);
    for (int i = 0; i < budget && imem_read; i++) @(negedge clk);
    chk(nm, 32'(imem_read), 32'd0);
  endtask

  initial begin
    logic [39:0] stall_pat;
    stall_pat     = 40'hC3_1E_60_F2_8D;
    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;

    // Reset for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(imem_read), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc_o", pc_o, 32'd0);
    chk("rst_pc_next_o", pc_next_o, 32'd0);
    chk("rst_instr", instruction_o, 32'd0);
    rst = 1'b0;
    #2;
    chk("first_read", 32'(imem_read), 32'd1);
    chk("first_addr", imem_address, 32'h4000_0060);

    // Streaming with single-cycle memory.
    @(negedge clk);
    chk("s0_valid", 32'(valid_o), 32'd1);
    chk("s0_pc", pc_o, 32'h4000_0060);
    chk("s0_pc_next", pc_next_o, 32'h4000_0064);
    chk("s0_instr", instruction_o, mem_word(32'h4000_0060));
    @(negedge clk);
    chk("s1_pc", pc_o, 32'h4000_0064);
    @(negedge clk);
    chk("s2_pc", pc_o, 32'h4000_0068);

    // Stall for three cycles: skid fills, request stops, outputs hold.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_read", 32'(imem_read), 32'd0);
      chk("stall_pc", pc_o, 32'h4000_0068);
      chk("stall_valid", 32'(valid_o), 32'd1);
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk("skid_pc", pc_o, 32'h4000_006C);
    chk("skid_instr", instruction_o, mem_word(32'h4000_006C));
    @(negedge clk);
    chk("post_skid_pc", pc_o, 32'h4000_0070);

    // Redirect with 3-cycle memory, one cycle into the request.
    lat = 3;
    @(negedge clk);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h4000_0101;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("drop_read", 32'(imem_read), 32'd1);
    chk("drop_addr_held", imem_address, 32'h4000_0074);
    chk("drop_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    chk("redir_addr", imem_address, 32'h4000_0100);
    chk("redir_valid", 32'(valid_o), 32'd0);
    wait_valid("redir_wait", 10);
    chk("redir_pc", pc_o, 32'h4000_0100);
    chk("redir_instr", instruction_o, mem_word(32'h4000_0100));

    // Redirect while FULL.
    lat     = 1;
    stall_i = 1'b1;
    wait_full("full_wait", 10);
    chk("full_valid", 32'(valid_o), 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h4000_0202;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("fredir_valid", 32'(valid_o), 32'd0);
    chk("fredir_read", 32'(imem_read), 32'd1);
    chk("fredir_addr", imem_address, 32'h4000_0200);
    stall_i = 1'b0;
    wait_valid("fredir_wait", 10);
    chk("fredir_pc", pc_o, 32'h4000_0200);

    // Redirect coinciding with a response, then PC wrap at the top.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("wrap_valid0", 32'(valid_o), 32'd0);
    chk("wrap_addr", imem_address, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_pc0", pc_o, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_pc1", pc_o, 32'hFFFF_FFFC);
    chk("wrap_next1", pc_next_o, 32'h0000_0000);
    @(negedge clk);
    chk("wrap_pc2", pc_o, 32'h0000_0000);
    chk("wrap_next2", pc_next_o, 32'h0000_0004);

    // Mixed stall pattern, back-to-back redirects; model checks every cycle.
    for (int i = 0; i < 40; i++) begin
      stall_i    = stall_pat[i];
      lat        = (i < 20) ? 1 : 2;
      redirect_i = (i == 9) || (i == 27) || (i == 28);
      redirect_pc_i = (i == 9)  ? 32'h4000_0400 :
                      (i == 27) ? 32'h4000_0500 : 32'h4000_0600;
      @(negedge clk);
    end
    redirect_i = 1'b0;
    stall_i    = 1'b0;

    // Reset while a discarded response is outstanding.
    lat = 100;
    repeat (3) @(negedge clk);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h4000_0300;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("rdrop_read", 32'(imem_read), 32'd1);
    chk("rdrop_valid", 32'(valid_o), 32'd0);
    rst        = 1'b1;
    force_resp = 1'b1;
    @(negedge clk);
    chk("rdrop_rst_read", 32'(imem_read), 32'd0);
    chk("rdrop_rst_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    force_resp = 1'b0;
    lat        = 1;
    rst        = 1'b0;
    #2;
    chk("restart_read", 32'(imem_read), 32'd1);
    chk("restart_addr", imem_address, RST_PC);
    wait_valid("restart_wait", 10);
    chk("restart_pc", pc_o, RST_PC);
    chk("restart_instr", instruction_o, mem_word(RST_PC));
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
